// File: rtl/spi_cmd_ctrl_if.sv
// Bus bundle between the SPI command sequencer, the SPI byte
// receiver/transmitter and the 8-bit memory it fronts.
// The master modport is the sequencer's view; slave is the peripherals' view.
interface spi_cmd_ctrl_if;
   logic       cs_n;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_busy;
   logic       tx_en;
   logic [7:0] tx_data;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] mem_rdata;
   logic       mem_wr;
   logic [7:0] mem_wdata;
   logic       err;

   modport master (
      input  cs_n, rx_done, rx_data, tx_busy, mem_rdata,
      output tx_en, tx_data, mem_addr, mem_rd, mem_wr, mem_wdata, err
   );

   modport slave (
      output cs_n, rx_done, rx_data, tx_busy, mem_rdata,
      input  tx_en, tx_data, mem_addr, mem_rd, mem_wr, mem_wdata, err
   );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes a command byte and an address byte inside a
// cs_n-framed transfer, then either streams write bytes into memory or
// prefetches read bytes for the transmitter, auto-incrementing the address.
// Protocol errors (unknown command, overrun, inter-byte timeout) raise a
// one-cycle err pulse.
module spi_cmd_ctrl #(
   parameter logic [7:0]  CMD_RD  = 8'h03,
   parameter logic [7:0]  CMD_WR  = 8'h02,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_cmd_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      RDREQ,
      RDWAIT,
      TXLOAD,
      TXWAIT,
      DISCARD
   } state_t;

   localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

   state_t     state;
   logic [9:0] gap_cnt;
   logic       op_rd;

   // Frame sequencer with registered strobes; mem_rd is raised on the edge
   // that enters RDREQ so read data is ready for capture in RDWAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         gap_cnt       <= '0;
         op_rd         <= 1'b0;
         bus.tx_en     <= 1'b0;
         bus.tx_data   <= 8'h00;
         bus.mem_addr  <= 8'h00;
         bus.mem_rd    <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_wdata <= 8'h00;
         bus.err       <= 1'b0;
      end else begin
         bus.tx_en  <= 1'b0;
         bus.mem_rd <= 1'b0;
         bus.mem_wr <= 1'b0;
         bus.err    <= 1'b0;

         if (bus.mem_wr) begin
            bus.mem_addr <= bus.mem_addr + 8'd1;
         end

         if (bus.cs_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
         end else if (state != IDLE && gap_cnt == TIMEOUT_CNT) begin
            bus.err <= 1'b1;
            state   <= IDLE;
            gap_cnt <= '0;
         end else begin
            if (bus.rx_done || state == IDLE) begin
               gap_cnt <= '0;
            end else begin
               gap_cnt <= gap_cnt + 10'd1;
            end

            case (state)
               IDLE: begin
                  if (bus.rx_done) begin
                     if (bus.rx_data == CMD_RD) begin
                        op_rd <= 1'b1;
                        state <= ADDR;
                     end else if (bus.rx_data == CMD_WR) begin
                        op_rd <= 1'b0;
                        state <= ADDR;
                     end else begin
                        bus.err <= 1'b1;
                        state   <= DISCARD;
                     end
                  end
               end

               ADDR: begin
                  if (bus.rx_done) begin
                     bus.mem_addr <= bus.rx_data;
                     if (op_rd) begin
                        bus.mem_rd <= 1'b1;
                        state      <= RDREQ;
                     end else begin
                        state <= WDATA;
                     end
                  end
               end

               WDATA: begin
                  if (bus.rx_done) begin
                     bus.mem_wr    <= 1'b1;
                     bus.mem_wdata <= bus.rx_data;
                  end
               end

               RDREQ: begin
                  if (bus.rx_done) begin
                     bus.err <= 1'b1;
                  end
                  state <= RDWAIT;
               end

               RDWAIT: begin
                  if (bus.rx_done) begin
                     bus.err <= 1'b1;
                  end
                  bus.tx_data <= bus.mem_rdata;
                  state       <= TXLOAD;
               end

               TXLOAD: begin
                  if (bus.rx_done) begin
                     bus.err <= 1'b1;
                  end
                  if (!bus.tx_busy) begin
                     bus.tx_en    <= 1'b1;
                     bus.mem_addr <= bus.mem_addr + 8'd1;
                     state        <= TXWAIT;
                  end
               end

               TXWAIT: begin
                  if (bus.rx_done) begin
                     bus.mem_rd <= 1'b1;
                     state      <= RDREQ;
                  end
               end

               DISCARD: begin
                  state <= DISCARD;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed testbench for spi_cmd_ctrl: a small memory model and a strobe
// monitor log every write, read and transmit so each scenario can be checked
// against hand-computed addresses, data and latencies.
module tb_spi_cmd_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   spi_cmd_ctrl_if bus();

   spi_cmd_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checkCount = 0;
   int failCount  = 0;
   int cyc        = 0;

   logic [7:0] mem [256];
   logic       preloadEn   = 1'b0;
   logic [7:0] preloadAddr = 8'h00;
   logic [7:0] preloadData = 8'h00;

   logic [15:0] wrLog[$];
   logic [7:0]  rdLog[$];
   logic [7:0]  txLog[$];
   int          txCycLog[$];
   int          errCount     = 0;
   int          errCyc       = 0;
   int          overlapCount = 0;

   int wrBase, rdBase, txBase, errBase;
   int lastRxCyc;

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter plus memory model with one-cycle read latency
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preloadEn) mem[preloadAddr] <= preloadData;
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Strobe monitor sampling on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (bus.mem_wr) wrLog.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.mem_rd) rdLog.push_back(bus.mem_addr);
      if (bus.tx_en) begin
         txLog.push_back(bus.tx_data);
         txCycLog.push_back(cyc);
      end
      if (bus.err) begin
         errCount = errCount + 1;
         errCyc   = cyc;
      end
      if (int'(bus.tx_en) + int'(bus.mem_rd) + int'(bus.mem_wr) > 1)
         overlapCount = overlapCount + 1;
   end

   // Hard stop in case something hangs
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      lastRxCyc   = cyc;
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      nextCycle();
      bus.rx_done = 1'b0;
      repeat (gap) nextCycle();
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      preloadAddr = a;
      preloadData = d;
      preloadEn   = 1'b1;
      nextCycle();
      preloadEn   = 1'b0;
   endtask

   task automatic startFrame();
      wrBase  = wrLog.size();
      rdBase  = rdLog.size();
      txBase  = txLog.size();
      errBase = errCount;
      bus.cs_n = 1'b0;
      nextCycle();
   endtask

   task automatic endFrame();
      bus.cs_n = 1'b1;
      repeat (3) nextCycle();
   endtask

   initial begin
      int addrCyc, dummyCyc, releaseCyc, waited, toDelay;

      rst_n       = 1'b0;
      bus.cs_n    = 1'b1;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_busy = 1'b0;
      repeat (3) nextCycle();

      checkOutput("rst_tx_en",     32'(bus.tx_en),     32'h0);
      checkOutput("rst_mem_rd",    32'(bus.mem_rd),    32'h0);
      checkOutput("rst_mem_wr",    32'(bus.mem_wr),    32'h0);
      checkOutput("rst_err",       32'(bus.err),       32'h0);
      checkOutput("rst_tx_data",   32'(bus.tx_data),   32'h0);
      checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
      checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
      rst_n = 1'b1;
      nextCycle();

      $display("[TB] write burst 02 10 AA BB CC");
      startFrame();
      applyStimulus(8'h02, 4);
      applyStimulus(8'h10, 4);
      applyStimulus(8'hAA, 4);
      applyStimulus(8'hBB, 4);
      applyStimulus(8'hCC, 4);
      checkOutput("wr_count",    32'(wrLog.size() - wrBase), 32'd3);
      checkOutput("wr0",         32'(wrLog[wrBase]),         32'h10AA);
      checkOutput("wr1",         32'(wrLog[wrBase + 1]),     32'h11BB);
      checkOutput("wr2",         32'(wrLog[wrBase + 2]),     32'h12CC);
      checkOutput("wr_addr_end", 32'(bus.mem_addr),          32'h13);
      checkOutput("wr_mem11",    32'(mem[8'h11]),            32'hBB);
      checkOutput("wr_err",      32'(errCount - errBase),    32'd0);
      endFrame();

      $display("[TB] read burst 03 20 + two dummies");
      preload(8'h20, 8'h5A);
      preload(8'h21, 8'hA5);
      preload(8'h22, 8'h3C);
      startFrame();
      applyStimulus(8'h03, 6);
      applyStimulus(8'h20, 8);
      addrCyc = lastRxCyc;
      applyStimulus(8'h00, 8);
      dummyCyc = lastRxCyc;
      applyStimulus(8'h00, 8);
      checkOutput("rd_addr0",   32'(rdLog[rdBase]),                32'h20);
      checkOutput("rd_tx_cnt",  32'(txLog.size() - txBase),        32'd3);
      checkOutput("rd_tx0",     32'(txLog[txBase]),                32'h5A);
      checkOutput("rd_lat0",    32'(txCycLog[txBase] - addrCyc),   32'd4);
      checkOutput("rd_tx1",     32'(txLog[txBase + 1]),            32'hA5);
      checkOutput("rd_lat1",    32'(txCycLog[txBase + 1] - dummyCyc), 32'd4);
      checkOutput("rd_tx2",     32'(txLog[txBase + 2]),            32'h3C);
      checkOutput("rd_err",     32'(errCount - errBase),           32'd0);
      endFrame();

      $display("[TB] address wrap write and read");
      startFrame();
      applyStimulus(8'h02, 4);
      applyStimulus(8'hFF, 4);
      applyStimulus(8'h11, 4);
      applyStimulus(8'h22, 4);
      checkOutput("wrap_wr_cnt", 32'(wrLog.size() - wrBase), 32'd2);
      checkOutput("wrap_wr0",    32'(wrLog[wrBase]),         32'hFF11);
      checkOutput("wrap_wr1",    32'(wrLog[wrBase + 1]),     32'h0022);
      endFrame();
      startFrame();
      applyStimulus(8'h03, 4);
      applyStimulus(8'hFF, 8);
      applyStimulus(8'h00, 8);
      checkOutput("wrap_tx0", 32'(txLog[txBase]),     32'h11);
      checkOutput("wrap_tx1", 32'(txLog[txBase + 1]), 32'h22);
      endFrame();

      $display("[TB] bad command then retry");
      startFrame();
      applyStimulus(8'h7E, 4);
      applyStimulus(8'h02, 4);
      applyStimulus(8'h10, 4);
      applyStimulus(8'hAA, 4);
      checkOutput("bad_err",    32'(errCount - errBase),     32'd1);
      checkOutput("bad_no_wr",  32'(wrLog.size() - wrBase),  32'd0);
      endFrame();
      startFrame();
      applyStimulus(8'h02, 4);
      applyStimulus(8'h10, 4);
      applyStimulus(8'hAA, 4);
      checkOutput("retry_wr_cnt", 32'(wrLog.size() - wrBase), 32'd1);
      checkOutput("retry_wr0",    32'(wrLog[wrBase]),         32'h10AA);
      checkOutput("retry_err",    32'(errCount - errBase),    32'd0);
      endFrame();

      $display("[TB] tx_busy stall with overrun");
      startFrame();
      applyStimulus(8'h03, 4);
      bus.tx_busy = 1'b1;
      applyStimulus(8'h20, 5);
      applyStimulus(8'hEE, 0);
      repeat (13) nextCycle();
      releaseCyc  = cyc;
      bus.tx_busy = 1'b0;
      repeat (6) nextCycle();
      checkOutput("busy_tx_cnt", 32'(txLog.size() - txBase),        32'd1);
      checkOutput("busy_tx0",    32'(txLog[txBase]),                32'h5A);
      checkOutput("busy_tx_cyc", 32'(txCycLog[txBase] - releaseCyc), 32'd1);
      checkOutput("busy_err",    32'(errCount - errBase),           32'd1);
      endFrame();

      $display("[TB] address byte arriving as cs_n rises");
      startFrame();
      applyStimulus(8'h03, 4);
      bus.rx_data = 8'h20;
      bus.rx_done = 1'b1;
      bus.cs_n    = 1'b1;
      nextCycle();
      bus.rx_done = 1'b0;
      repeat (6) nextCycle();
      checkOutput("abort_no_rd", 32'(rdLog.size() - rdBase), 32'd0);
      checkOutput("abort_no_tx", 32'(txLog.size() - txBase), 32'd0);
      startFrame();
      applyStimulus(8'h02, 4);
      applyStimulus(8'h30, 4);
      applyStimulus(8'h77, 4);
      checkOutput("abort_next_wr", 32'(wrLog[wrBase]), 32'h3077);
      endFrame();

      $display("[TB] inter-byte timeout");
      startFrame();
      applyStimulus(8'h03, 0);
      addrCyc = lastRxCyc;
      waited  = 0;
      while (errCount == errBase && waited < 1200) begin
         nextCycle();
         waited++;
      end
      repeat (4) nextCycle();
      toDelay = errCyc - addrCyc;
      checkOutput("to_err_cnt",  32'(errCount - errBase), 32'd1);
      checkOutput("to_delay_ok", 32'(toDelay >= 1023 && toDelay <= 1026), 32'd1);
      applyStimulus(8'h02, 4);
      applyStimulus(8'h40, 4);
      applyStimulus(8'h99, 4);
      checkOutput("to_idle_wr", 32'(wrLog[wrBase]), 32'h4099);
      endFrame();

      $display("[TB] asynchronous reset mid-burst");
      preload(8'h50, 8'h11);
      startFrame();
      applyStimulus(8'h02, 4);
      applyStimulus(8'h50, 4);
      applyStimulus(8'h66, 0);
      checkOutput("mid_wr_pre", 32'(bus.mem_wr), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_mem_wr",    32'(bus.mem_wr),    32'h0);
      checkOutput("mid_mem_addr",  32'(bus.mem_addr),  32'h0);
      checkOutput("mid_mem_wdata", 32'(bus.mem_wdata), 32'h0);
      checkOutput("mid_tx_data",   32'(bus.tx_data),   32'h0);
      nextCycle();
      checkOutput("mid_mem50",     32'(mem[8'h50]),    32'h11);
      bus.cs_n = 1'b1;
      rst_n    = 1'b1;
      repeat (2) nextCycle();

      checkOutput("strobe_overlap", 32'(overlapCount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
